// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: drives the four pipeline latch controls and the PC write enable,
// and keeps stall/flush counters plus a sticky data-memory timeout flag.
module pipeline_hazard_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic [1:0]       ctrl_if_id,
  output logic [1:0]       ctrl_id_ex,
  output logic [1:0]       ctrl_ex_mem,
  output logic [1:0]       ctrl_mem_wb,
  output logic             pc_write,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout_err
);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_MEM_WAIT} state_t;

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [1:0] CTL_XFER   = 2'b00;
  localparam logic [1:0] CTL_HOLD   = 2'b01;
  localparam logic [1:0] CTL_BUBBLE = 2'b10;
  localparam logic [1:0] CTL_CLEAR  = 2'b11;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [INIT_W-1:0] INIT_END = INIT_W'(INIT_CYCLES - 1);

  state_t            state, next_state;
  logic [INIT_W-1:0] init_cnt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              pend_flush, pend_flush_next;
  logic              stall_inc, flush_inc, err_set;
  logic              in_init, init_done, load_use;

  // With INIT_CYCLES=0 the INIT state behaves exactly like RUN.
  assign in_init   = (state == ST_INIT) && (INIT_CYCLES != 0);
  assign init_done = (init_cnt == INIT_END);
  assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    ctrl_if_id      = CTL_XFER;
    ctrl_id_ex      = CTL_XFER;
    ctrl_ex_mem     = CTL_XFER;
    ctrl_mem_wb     = CTL_XFER;
    pc_write        = 1'b1;
    next_state      = state;
    pend_flush_next = pend_flush;
    wait_cnt_next   = wait_cnt;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    err_set         = 1'b0;

    if (rst || in_init) begin
      ctrl_if_id  = CTL_CLEAR;
      ctrl_id_ex  = CTL_CLEAR;
      ctrl_ex_mem = CTL_CLEAR;
      ctrl_mem_wb = CTL_CLEAR;
      pc_write    = 1'b0;
      if (!rst && init_done)
        next_state = ST_RUN;
    end else if (mem_busy) begin
      ctrl_if_id  = CTL_HOLD;
      ctrl_id_ex  = CTL_HOLD;
      ctrl_ex_mem = CTL_HOLD;
      ctrl_mem_wb = CTL_BUBBLE;
      pc_write    = 1'b0;
      next_state  = ST_MEM_WAIT;
      stall_inc   = 1'b1;
      // A branch resolved while frozen is remembered and applied once memory is ready.
      if (branch_taken)
        pend_flush_next = 1'b1;
      if (state != ST_MEM_WAIT)
        wait_cnt_next = WAIT_W'(1);
      else if (wait_cnt != WAIT_MAX)
        wait_cnt_next = wait_cnt + 1'b1;
      err_set = (wait_cnt_next == WAIT_MAX);
    end else begin
      next_state = ST_RUN;
      if (branch_taken || pend_flush) begin
        ctrl_if_id      = CTL_BUBBLE;
        ctrl_id_ex      = CTL_BUBBLE;
        flush_inc       = 1'b1;
        pend_flush_next = 1'b0;
      end else if (load_use) begin
        ctrl_if_id = CTL_HOLD;
        ctrl_id_ex = CTL_BUBBLE;
        pc_write   = 1'b0;
        stall_inc  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_INIT;
      init_cnt        <= '0;
      wait_cnt        <= '0;
      pend_flush      <= 1'b0;
      stall_count     <= '0;
      flush_count     <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state      <= next_state;
      pend_flush <= pend_flush_next;
      wait_cnt   <= wait_cnt_next;
      if (in_init && !init_done)
        init_cnt <= init_cnt + 1'b1;
      if (stall_inc && (stall_count != CNT_MAX))
        stall_count <= stall_count + 1'b1;
      if (flush_inc && (flush_count != CNT_MAX))
        flush_count <= flush_count + 1'b1;
      if (err_set)
        mem_timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a default instance plus a CNT_W=4, INIT_CYCLES=0
// instance sharing the same stimulus for saturation and zero-length init.
module tb_pipeline_hazard_ctrl;

  localparam logic [8:0] P_RUN = 9'b00_00_00_00_1;
  localparam logic [8:0] P_CLR = 9'b11_11_11_11_0;
  localparam logic [8:0] P_LU  = 9'b01_10_00_00_0;
  localparam logic [8:0] P_FL  = 9'b10_10_00_00_1;
  localparam logic [8:0] P_FRZ = 9'b01_01_01_10_0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
  logic        id_uses_rt = 1'b0, ex_mem_read = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;

  logic [1:0]  m_if_id, m_id_ex, m_ex_mem, m_mem_wb;
  logic        m_pc_write, m_err;
  logic [31:0] m_stall, m_flush;
  logic [1:0]  s_if_id, s_id_ex, s_ex_mem, s_mem_wb;
  logic        s_pc_write, s_err;
  logic [3:0]  s_stall, s_flush;

  logic [8:0]  ctl_main, ctl_sat;
  assign ctl_main = {m_if_id, m_id_ex, m_ex_mem, m_mem_wb, m_pc_write};
  assign ctl_sat  = {s_if_id, s_id_ex, s_ex_mem, s_mem_wb, s_pc_write};

  int num_checks = 0;
  int num_fails  = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .ctrl_if_id(m_if_id), .ctrl_id_ex(m_id_ex), .ctrl_ex_mem(m_ex_mem), .ctrl_mem_wb(m_mem_wb),
    .pc_write(m_pc_write), .stall_count(m_stall), .flush_count(m_flush), .mem_timeout_err(m_err)
  );

  pipeline_hazard_ctrl #(.INIT_CYCLES(0), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .ctrl_if_id(s_if_id), .ctrl_id_ex(s_id_ex), .ctrl_ex_mem(s_ex_mem), .ctrl_mem_wb(s_mem_wb),
    .pc_write(s_pc_write), .stall_count(s_stall), .flush_count(s_flush), .mem_timeout_err(s_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                               input logic mem_read, input logic [4:0] rd,
                               input logic branch, input logic busy);
    @(negedge clk);
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = uses_rt;
    ex_mem_read  = mem_read;
    ex_rd        = rd;
    branch_taken = branch;
    mem_busy     = busy;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset and init sequence
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_ctl", 32'(ctl_main), 32'(P_CLR));
    checkOutput("rst_ctl_sat", 32'(ctl_sat), 32'(P_CLR));
    checkOutput("rst_stall", m_stall, 0);
    checkOutput("rst_flush", m_flush, 0);
    checkOutput("rst_err", 32'(m_err), 0);
    rst = 1'b0;
    #1;
    checkOutput("init0_ctl", 32'(ctl_main), 32'(P_CLR));
    checkOutput("init0_sat_run", 32'(ctl_sat), 32'(P_RUN));
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("init1_ctl", 32'(ctl_main), 32'(P_CLR));
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("run_ctl", 32'(ctl_main), 32'(P_RUN));

    // Load-use detection
    applyStimulus(5, 0, 0, 1, 5, 0, 0);
    checkOutput("lu_rs_ctl", 32'(ctl_main), 32'(P_LU));
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("lu_stall1", m_stall, 1);
    checkOutput("lu_rd0_ctl", 32'(ctl_main), 32'(P_RUN));
    applyStimulus(3, 7, 1, 1, 7, 0, 0);
    checkOutput("lu_rd0_stall", m_stall, 1);
    checkOutput("lu_rt_ctl", 32'(ctl_main), 32'(P_LU));
    applyStimulus(3, 7, 0, 1, 7, 0, 0);
    checkOutput("lu_rt_stall", m_stall, 2);
    checkOutput("lu_rt_unused_ctl", 32'(ctl_main), 32'(P_RUN));

    // Branch flush beats a simultaneous load-use
    applyStimulus(5, 0, 0, 1, 5, 1, 0);
    checkOutput("br_lu_ctl", 32'(ctl_main), 32'(P_FL));
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("br_flush", m_flush, 1);
    checkOutput("br_stall", m_stall, 2);

    // Three-cycle memory wait with a branch remembered in the middle
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("mw1_ctl", 32'(ctl_main), 32'(P_FRZ));
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    checkOutput("mw2_ctl", 32'(ctl_main), 32'(P_FRZ));
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("mw3_ctl", 32'(ctl_main), 32'(P_FRZ));
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("mw_exit_ctl", 32'(ctl_main), 32'(P_FL));
    checkOutput("mw_stall", m_stall, 5);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("mw_flush", m_flush, 2);
    checkOutput("mw_after_ctl", 32'(ctl_main), 32'(P_RUN));

    // Memory timeout after 64 consecutive busy cycles
    for (int i = 1; i <= 64; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      if (i == 1 || i == 64) checkOutput("to_frz_ctl", 32'(ctl_main), 32'(P_FRZ));
      if (i == 63 || i == 64) checkOutput("to_err_pre", 32'(m_err), 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("to_err_set", 32'(m_err), 1);
    checkOutput("to_exit_ctl", 32'(ctl_main), 32'(P_RUN));
    checkOutput("to_stall", m_stall, 69);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("to_err_sticky", 32'(m_err), 1);

    // Reset during a memory wait with a pending flush
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mrst_ctl", 32'(ctl_main), 32'(P_CLR));
    checkOutput("mrst_err", 32'(m_err), 0);
    checkOutput("mrst_stall", m_stall, 0);
    checkOutput("mrst_flush", m_flush, 0);
    checkOutput("mrst_sat_stall", 32'(s_stall), 0);
    checkOutput("mrst_sat_flush", 32'(s_flush), 0);
    checkOutput("mrst_sat_err", 32'(s_err), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    checkOutput("mrst_init0_ctl", 32'(ctl_main), 32'(P_CLR));
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("mrst_init1_ctl", 32'(ctl_main), 32'(P_CLR));
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("mrst_run_ctl", 32'(ctl_main), 32'(P_RUN));
    checkOutput("mrst_noflush", m_flush, 0);

    // Saturation of the 4-bit stall counter
    for (int i = 0; i < 20; i++) begin
      applyStimulus(9, 0, 0, 1, 9, 0, 0);
      if (i == 0) begin
        checkOutput("sat_lu_ctl", 32'(ctl_main), 32'(P_LU));
        checkOutput("sat_lu_ctl_sat", 32'(ctl_sat), 32'(P_LU));
      end
      if (i == 14) checkOutput("sat_14", 32'(s_stall), 14);
      if (i == 15) checkOutput("sat_15", 32'(s_stall), 15);
      if (i == 19) checkOutput("sat_hold", 32'(s_stall), 15);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("sat_final", 32'(s_stall), 15);
    checkOutput("sat_main_stall", m_stall, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline register set: drives the 2-bit control input of the IF/ID, ID/EX, EX/MEM and MEM/WB latches, plus the PC write enable.
- Detects load-use hazards, taken-branch flushes and data-memory wait states. Runs a post-reset clear sequence.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
- INIT_CYCLES, 2, cycles after reset release during which all latches are forced to clear.
- MEM_TIMEOUT, 64, consecutive mem_busy cycles at which mem_timeout_err sets.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of instruction in EX
- branch_taken  in  1  branch in EX resolved taken this cycle
- mem_busy  in  1  data memory not ready this cycle
- ctrl_if_id  out  2  IF/ID latch control
- ctrl_id_ex  out  2  ID/EX latch control
- ctrl_ex_mem  out  2  EX/MEM latch control
- ctrl_mem_wb  out  2  MEM/WB latch control
- pc_write  out  1  PC update enable
- stall_count  out  CNT_W  cycles spent in load-use or mem-wait stall
- flush_count  out  CNT_W  branch flushes applied
- mem_timeout_err  out  1  sticky timeout flag

Behaviour:
- Latch control encoding: 00 transfer, 01 hold, 10 bubble, 11 clear.
- Control outputs are combinational from the registered state plus the current inputs. They take effect at the same clock edge at which the hazard is seen. Counters, state, pend_flush and err are registered.
- States: INIT, RUN, MEM_WAIT.
- rst high (async): state=INIT, init counter=0, pend_flush=0, counters=0, mem_timeout_err=0. While rst is high or in INIT: all ctrl=11, pc_write=0.
- INIT: increments the init counter each cycle. After INIT_CYCLES cycles, goes to RUN (INIT_CYCLES=0 means RUN on the first cycle).
- Outputs in RUN, first match wins:
  1. mem_busy=1: IF/ID, ID/EX, EX/MEM=01; MEM/WB=10; pc_write=0; next state MEM_WAIT.
  2. branch_taken=1 or pend_flush=1: IF/ID=10, ID/EX=10, EX/MEM=00, MEM/WB=00; pc_write=1; flush_count+1; pend_flush clears.
  3. Load-use: ex_mem_read=1, ex_rd!=0, and (ex_rd==id_rs or (id_uses_rt and ex_rd==id_rt)). Then IF/ID=01, ID/EX=10, others 00; pc_write=0; stall_count+1.
  4. Otherwise: all 00, pc_write=1.
- Branch and load-use in the same cycle: the flush wins; the load-use is not counted.
- MEM_WAIT: outputs are the same as RUN rule 1 while mem_busy=1. branch_taken seen in MEM_WAIT sets pend_flush. When mem_busy=0, outputs are evaluated by RUN rules 2-4 in that same cycle, and state returns to RUN.
- Each mem_busy cycle increments stall_count and the wait counter. The wait counter resets on entry to MEM_WAIT.
- When the wait counter reaches MEM_TIMEOUT, mem_timeout_err=1. It stays set until rst; the pipeline remains frozen while mem_busy persists.
- Counters saturate at all-ones and do not wrap.
- Reset mid-operation aborts any stall or flush. pend_flush is lost.

Test Plan:
- Reset release, INIT_CYCLES=2 -> ctrl=11 and pc_write=0 for 2 cycles, then all 00 and pc_write=1; counters 0.
- ex_mem_read=1, ex_rd=5, id_rs=5 for 1 cycle -> IF/ID=01, ID/EX=10, pc_write=0, stall_count=1. Same with ex_rd=0 -> all 00, no stall.
- branch_taken=1 together with a load-use match -> IF/ID=10, ID/EX=10, pc_write=1, flush_count=1, stall_count unchanged.
- mem_busy high for 3 cycles with branch_taken pulsed in cycle 2 -> 3 frozen cycles (MEM/WB=10), stall_count=3. The cycle mem_busy drops shows the flush pattern; flush_count=1.
- mem_busy held 64 cycles -> mem_timeout_err rises on cycle 64 and stays 1 after mem_busy drops, until rst.
- stall_count preloaded near saturation (CNT_W=4), 20 load-use cycles -> holds at 15.
- rst asserted during MEM_WAIT with pend_flush set -> outputs immediately 11; after INIT no flush occurs.
